// File: rtl/fpga_bootrom_arbiter_if.sv
// Requester-side bus bundle for the bootrom arbiter: per-master request/address/write-enable
// and per-master grant/response, flattened with master m occupying bit m / bits [32m+31:32m].
interface fpga_bootrom_arbiter_if #(
    parameter int NB_MASTERS = 2
);
    logic [NB_MASTERS-1:0]    req;
    logic [NB_MASTERS*32-1:0] addr;
    logic [NB_MASTERS-1:0]    we;
    logic [NB_MASTERS-1:0]    gnt;
    logic [NB_MASTERS-1:0]    rvalid;
    logic [NB_MASTERS*32-1:0] rdata;
    logic [NB_MASTERS-1:0]    err;

    modport master (
        output req, addr, we,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/fpga_bootrom_arbiter.sv
// Shares the single-port bootrom between NB_MASTERS requesters with a fixed 1-cycle response.
// Define FPGA_BOOTROM_ARB_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module fpga_bootrom_arbiter #(
    parameter int          NB_MASTERS     = 2,
    parameter int          ROM_ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h1A000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fpga_bootrom_arbiter_if.slave     bus,
    output logic                      rom_cen,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]               rom_q
);
    localparam int IDW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

    logic [IDW-1:0]            rr_q;
    logic                      gnt_any;
    logic [IDW-1:0]            gnt_id;
    logic [31:0]               gnt_addr;
    logic                      gnt_we;
    logic [31:0]               off;
    logic                      legal;
    logic                      gnt_valid;
    logic                      rom_hit;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q;
    logic                      rsp_valid_q;
    logic [IDW-1:0]            rsp_id_q;
    logic                      rsp_err_q;

    // Search starts at rr_q; with rr_q tied to 0 this degenerates to lowest-index priority.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            idx = (int'(rr_q) + i) % NB_MASTERS;
            if (!gnt_any && bus.req[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign gnt_valid = rst_n && gnt_any;
    assign gnt_addr  = bus.addr[32*int'(gnt_id) +: 32];
    assign gnt_we    = bus.we[gnt_id];
    assign off       = gnt_addr - BASE_ADDR;
    // 64-bit compare keeps the window size exact even when 4*ROM_WORDS reaches 2**32.
    assign legal     = !gnt_we && (gnt_addr[1:0] == 2'b00)
                       && ({32'b0, off} < (64'd4 << ROM_ADDR_WIDTH));
    assign rom_hit   = gnt_valid && legal;
    assign rom_cen   = !rom_hit;
    assign rom_addr  = rom_hit ? off[ROM_ADDR_WIDTH+1:2] : rom_addr_q;

    always_comb begin
        bus.gnt = '0;
        if (gnt_valid) bus.gnt[gnt_id] = 1'b1;
    end

`ifdef FPGA_BOOTROM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (gnt_any) begin
            rr_q <= IDW'((int'(gnt_id) + 1) % NB_MASTERS);
        end
    end
`else
    assign rr_q = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= gnt_any;
            rsp_id_q    <= gnt_id;
            rsp_err_q   <= !legal;
            if (rom_hit) rom_addr_q <= off[ROM_ADDR_WIDTH+1:2];
        end
    end

    // Error responses return zero data rather than whatever the ROM last produced.
    always_comb begin
        bus.rvalid = '0;
        bus.err    = '0;
        bus.rdata  = '0;
        for (int m = 0; m < NB_MASTERS; m++) begin
            if (rsp_valid_q && (rsp_id_q == IDW'(m))) begin
                bus.rvalid[m] = 1'b1;
                bus.err[m]    = rsp_err_q;
                if (!rsp_err_q) bus.rdata[32*m +: 32] = rom_q;
            end
        end
    end
endmodule

// File: tb/tb_fpga_bootrom_arbiter.sv
// Directed bench for fpga_bootrom_arbiter with a behavioural ROM returning 0xC0DE0000 | word.
// Inputs change on the falling edge; all outputs are sampled 1 ns later.
module tb_fpga_bootrom_arbiter;
    logic        clk;
    logic        rst_n;
    logic        rom_cen;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q;

    int n_cmp = 0;
    int n_err = 0;

    fpga_bootrom_arbiter_if #(.NB_MASTERS(2)) bus ();

    fpga_bootrom_arbiter #(
        .NB_MASTERS    (2),
        .ROM_ADDR_WIDTH(10),
        .BASE_ADDR     (32'h1A000000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .rom_cen (rom_cen),
        .rom_addr(rom_addr),
        .rom_q   (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rom_q = 32'h0;
    always @(posedge clk) if (!rom_cen) rom_q <= 32'hC0DE0000 | {22'h0, rom_addr};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1);
        @(negedge clk);
        bus.req  = r;
        bus.we   = w;
        bus.addr = {a1, a0};
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] v, input logic [1:0] e,
                             input logic [63:0] d);
        check({tag, "_rvalid"}, {62'h0, bus.rvalid}, {62'h0, v});
        check({tag, "_err"},    {62'h0, bus.err},    {62'h0, e});
        check({tag, "_rdata"},  bus.rdata, d);
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.req  = 2'b00;
        bus.we   = 2'b00;
        bus.addr = 64'h0;
        #2;
        check("rst_gnt", {62'h0, bus.gnt}, 64'h0);
        check_rsp("rst", 2'b00, 2'b00, 64'h0);
        check("rst_cen", {63'h0, rom_cen}, 64'h1);
        check("rst_addr", {54'h0, rom_addr}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1 single legal read of word 2
        drive(2'b01, 2'b00, 32'h1A000008, 32'h0);
        check("t1_gnt", {62'h0, bus.gnt}, 64'h1);
        check("t1_cen", {63'h0, rom_cen}, 64'h0);
        check("t1_addr", {54'h0, rom_addr}, 64'd2);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        check_rsp("t1", 2'b01, 2'b00, 64'h00000000_C0DE0002);
        check("t1_idle_cen", {63'h0, rom_cen}, 64'h1);
        check("t1_idle_gnt", {62'h0, bus.gnt}, 64'h0);

        // T2 illegal accesses from m1: write, misaligned, out of range, below base
        drive(2'b10, 2'b10, 32'h0, 32'h1A000000);
        check("t2w_gnt", {62'h0, bus.gnt}, 64'h2);
        check("t2w_cen", {63'h0, rom_cen}, 64'h1);
        check("t2w_addr_hold", {54'h0, rom_addr}, 64'd2);
        drive(2'b10, 2'b00, 32'h0, 32'h1A000002);
        check_rsp("t2w", 2'b10, 2'b10, 64'h0);
        check("t2m_cen", {63'h0, rom_cen}, 64'h1);
        drive(2'b10, 2'b00, 32'h0, 32'h1A001000);
        check_rsp("t2m", 2'b10, 2'b10, 64'h0);
        check("t2o_cen", {63'h0, rom_cen}, 64'h1);
        drive(2'b10, 2'b00, 32'h0, 32'h19FFFFFC);
        check_rsp("t2o", 2'b10, 2'b10, 64'h0);
        check("t2b_cen", {63'h0, rom_cen}, 64'h1);
        drive(2'b10, 2'b00, 32'h0, 32'h1A000FFC);
        check_rsp("t2b", 2'b10, 2'b10, 64'h0);
        check("t2last_cen", {63'h0, rom_cen}, 64'h0);
        check("t2last_addr", {54'h0, rom_addr}, 64'd1023);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        check_rsp("t2last", 2'b10, 2'b00, 64'hC0DE03FF_00000000);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        check_rsp("t2_quiet", 2'b00, 2'b00, 64'h0);

        // T3/T4 contention: m0 reads word 4, m1 reads word 5, 4 cycles
`ifdef FPGA_BOOTROM_ARB_RR_EN
        drive(2'b11, 2'b00, 32'h1A000010, 32'h1A000014);
        check("t3_g0", {62'h0, bus.gnt}, 64'h1);
        check_rsp("t3_r0", 2'b00, 2'b00, 64'h0);
        drive(2'b11, 2'b00, 32'h1A000010, 32'h1A000014);
        check("t3_g1", {62'h0, bus.gnt}, 64'h2);
        check_rsp("t3_r1", 2'b01, 2'b00, 64'h00000000_C0DE0004);
        drive(2'b11, 2'b00, 32'h1A000010, 32'h1A000014);
        check("t3_g2", {62'h0, bus.gnt}, 64'h1);
        check_rsp("t3_r2", 2'b10, 2'b00, 64'hC0DE0005_00000000);
        drive(2'b11, 2'b00, 32'h1A000010, 32'h1A000014);
        check("t3_g3", {62'h0, bus.gnt}, 64'h2);
        check_rsp("t3_r3", 2'b01, 2'b00, 64'h00000000_C0DE0004);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        check_rsp("t3_r4", 2'b10, 2'b00, 64'hC0DE0005_00000000);
`else
        drive(2'b11, 2'b00, 32'h1A000010, 32'h1A000014);
        check("t4_g0", {62'h0, bus.gnt}, 64'h1);
        check_rsp("t4_r0", 2'b00, 2'b00, 64'h0);
        for (int k = 1; k < 4; k++) begin
            drive(2'b11, 2'b00, 32'h1A000010, 32'h1A000014);
            check($sformatf("t4_g%0d", k), {62'h0, bus.gnt}, 64'h1);
            check_rsp($sformatf("t4_r%0d", k), 2'b01, 2'b00, 64'h00000000_C0DE0004);
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        check_rsp("t4_r4", 2'b01, 2'b00, 64'h00000000_C0DE0004);
`endif

        // T5 streaming words 0..7 from m0
        for (int k = 0; k < 8; k++) begin
            drive(2'b01, 2'b00, 32'h1A000000 + 32'(4 * k), 32'h0);
            check($sformatf("t5_gnt%0d", k), {62'h0, bus.gnt}, 64'h1);
            check($sformatf("t5_addr%0d", k), {54'h0, rom_addr}, 64'(k));
            if (k > 0)
                check_rsp($sformatf("t5_r%0d", k - 1), 2'b01, 2'b00,
                          {32'h0, 32'hC0DE0000 + 32'(k - 1)});
        end
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        check_rsp("t5_r7", 2'b01, 2'b00, 64'h00000000_C0DE0007);

        // T6 reset the cycle after a grant
        drive(2'b01, 2'b00, 32'h1A00000C, 32'h0);
        check("t6_gnt", {62'h0, bus.gnt}, 64'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_rsp("t6_inrst", 2'b00, 2'b00, 64'h0);
        check("t6_gnt_rst", {62'h0, bus.gnt}, 64'h0);
        check("t6_cen_rst", {63'h0, rom_cen}, 64'h1);
        check("t6_addr_rst", {54'h0, rom_addr}, 64'h0);
        @(negedge clk);
        bus.req = 2'b00;
        rst_n   = 1'b1;
        #1;
        check_rsp("t6_rel", 2'b00, 2'b00, 64'h0);
        drive(2'b00, 2'b00, 32'h0, 32'h0);
        check_rsp("t6_after", 2'b00, 2'b00, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
